// File: rtl/pacman_nav.sv
// pacman_nav: button-driven heading and fixed-rate movement of PacMan around
// a 2x4 grid, plus the digit scan that multiplexes the seven-segment display.
//
// Parameters:
//   MOVE_DIV  - clock cycles per PacMan step (>= 2)
//   SCAN_DIV  - clock cycles each digit stays selected (>= 2)
//   DB_CYCLES - stable cycles needed to accept a button level (>= 2);
//               only used when PACMAN_DEBOUNCE_EN is defined
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active low
//   btn_up/btn_down/btn_left/btn_right  in  raw asynchronous buttons, active high
//   state      out  [3:0] position code (A=0 B=1 C=3 D=4 / E=5 F=6 G=7 H=8)
//   direction  out  [2:0] heading (up=0 down=1 left=2 right=3)
//   idx        out  [2:0] digit being scanned, 0..3
//   anodes     out  [3:0] active-low digit enables, anodes[3-idx] low
//   move_pulse out  high on the first cycle state holds a new position
//
// Build option:
//   PACMAN_DEBOUNCE_EN - insert a per-button debounce counter after the
//                        synchronizer; otherwise the synchronized level is
//                        used directly.
module pacman_nav #(
  parameter int unsigned MOVE_DIV  = 50_000_000,
  parameter int unsigned SCAN_DIV  = 100_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [3:0] state,
  output logic [2:0] direction,
  output logic [2:0] idx,
  output logic [3:0] anodes,
  output logic       move_pulse
);

  localparam int unsigned MW = $clog2(MOVE_DIV);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  typedef enum logic [2:0] {
    DIR_UP    = 3'd0,
    DIR_DOWN  = 3'd1,
    DIR_LEFT  = 3'd2,
    DIR_RIGHT = 3'd3
  } dir_t;

  // Bit order everywhere: {up, down, left, right}
  logic [3:0] btn_raw;
  logic [3:0] sync1, sync2;
  logic [3:0] acc;
  logic [3:0] acc_prev;
  logic [3:0] press;

  dir_t          dir_q, dir_d;
  logic          row_q, row_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    state_d;
  logic [MW-1:0] move_cnt;
  logic          move_edge;
  logic [SW-1:0] scan_cnt;
  logic          scan_edge;
  logic [1:0]    idx_q, idx_d;

  assign btn_raw   = {btn_up, btn_down, btn_left, btn_right};
  assign press     = acc & ~acc_prev;
  assign direction = dir_q;
  assign idx       = {1'b0, idx_q};

`ifdef PACMAN_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DB_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  logic [DW-1:0] db_cnt [4];
  logic [3:0]    db_lvl;

  // Count consecutive edges on which the synchronized level disagrees with
  // the accepted level; any agreement (a bounce back) restarts the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      db_lvl <= '0;
      for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign acc = db_lvl;
`else
  assign acc = sync2;
`endif

  // The freshly pressed heading is resolved before the step so that a press
  // landing on a move edge steers that very step.
  always_comb begin
    dir_d     = dir_q;
    row_d     = row_q;
    col_d     = col_q;
    state_d   = state;
    move_edge = (move_cnt == MOVE_LAST);
    scan_edge = (scan_cnt == SCAN_LAST);
    idx_d     = scan_edge ? idx_q + 2'd1 : idx_q;

    if (press[3])      dir_d = DIR_UP;
    else if (press[2]) dir_d = DIR_DOWN;
    else if (press[1]) dir_d = DIR_LEFT;
    else if (press[0]) dir_d = DIR_RIGHT;

    if (move_edge) begin
      unique case (dir_d)
        DIR_UP, DIR_DOWN: row_d = ~row_q;
        DIR_LEFT:         col_d = col_q - 2'd1;
        DIR_RIGHT:        col_d = col_q + 2'd1;
        default:          ;
      endcase
      // Top row skips code 2: cols 2,3 map to 3,4. Bottom row is 5 + col.
      if (row_d) state_d = 4'd5 + {2'b00, col_d};
      else       state_d = {2'b00, col_d} + {3'b000, col_d[1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1      <= '0;
      sync2      <= '0;
      acc_prev   <= '0;
      dir_q      <= DIR_RIGHT;
      row_q      <= 1'b0;
      col_q      <= '0;
      state      <= '0;
      move_cnt   <= '0;
      move_pulse <= 1'b0;
      scan_cnt   <= '0;
      idx_q      <= '0;
      anodes     <= 4'b0111;
    end else begin
      sync1      <= btn_raw;
      sync2      <= sync1;
      acc_prev   <= acc;
      dir_q      <= dir_d;
      row_q      <= row_d;
      col_q      <= col_d;
      state      <= state_d;
      move_pulse <= move_edge;
      move_cnt   <= move_edge ? '0 : move_cnt + MW'(1);
      scan_cnt   <= scan_edge ? '0 : scan_cnt + SW'(1);
      idx_q      <= idx_d;
      anodes     <= ~(4'b1000 >> idx_d);
    end
  end

endmodule

// File: tb/tb_pacman_nav.sv
module tb_pacman_nav;

  logic       clk;
  logic       rst;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic [3:0] state;
  logic [2:0] direction;
  logic [2:0] idx;
  logic [3:0] anodes;
  logic       move_pulse;

`ifdef PACMAN_DEBOUNCE_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  pacman_nav #(
    .MOVE_DIV (8),
    .SCAN_DIV (4),
    .DB_CYCLES(5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .state     (state),
    .direction (direction),
    .idx       (idx),
    .anodes    (anodes),
    .move_pulse(move_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          do_rst;
    logic [3:0]  btn;    // {up, down, left, right}
    int unsigned ncyc;   // rising edges to run before sampling
    logic [3:0]  st;
    logic [2:0]  dir;
    logic [2:0]  ix;
    logic [3:0]  an;
    logic        pl;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];
  vec_t exp_q [$];

  int checks = 0;
  int errors = 0;

  function automatic vec_t v(bit r, logic [3:0] b, int unsigned n, logic [3:0] s,
                             logic [2:0] d, logic [2:0] x, logic [3:0] a, logic p);
    vec_t t;
    t.do_rst = r; t.btn = b; t.ncyc = n; t.st = s; t.dir = d; t.ix = x; t.an = a; t.pl = p;
    return t;
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0d, expected %0d", name, i, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int   pulses;

    // Idle after reset: right-moving, steps every 8 edges, digit every 4 edges.
    vecs[0]  = v(1, 4'b0000, 0, 4'd0, 3'd3, 3'd0, 4'b0111, 1'b0);
    vecs[1]  = v(0, 4'b0000, 4, 4'd0, 3'd3, 3'd1, 4'b1011, 1'b0);
    vecs[2]  = v(0, 4'b0000, 3, 4'd0, 3'd3, 3'd1, 4'b1011, 1'b0);
    vecs[3]  = v(0, 4'b0000, 1, 4'd1, 3'd3, 3'd2, 4'b1101, 1'b1);
    vecs[4]  = v(0, 4'b0000, 1, 4'd1, 3'd3, 3'd2, 4'b1101, 1'b0);
    vecs[5]  = v(0, 4'b0000, 3, 4'd1, 3'd3, 3'd3, 4'b1110, 1'b0);
    vecs[6]  = v(0, 4'b0000, 4, 4'd3, 3'd3, 3'd0, 4'b0111, 1'b1);
    vecs[7]  = v(0, 4'b0000, 8, 4'd4, 3'd3, 3'd2, 4'b1101, 1'b1);
    vecs[8]  = v(0, 4'b0000, 8, 4'd0, 3'd3, 3'd0, 4'b0111, 1'b1);
    vecs[9]  = v(0, 4'b0000, 8, 4'd1, 3'd3, 3'd2, 4'b1101, 1'b1);
    // At B press up: row toggles to F, then back to B.
    vecs[10] = v(0, 4'b1000, 2, 4'd1, 3'd3, 3'd2, 4'b1101, 1'b0);
    vecs[11] = v(0, 4'b1000, 1, 4'd1, DB ? 3'd3 : 3'd0, 3'd2, 4'b1101, 1'b0);
    vecs[12] = v(0, 4'b1000, 5, 4'd6, 3'd0, 3'd0, 4'b0111, 1'b1);
    vecs[13] = v(0, 4'b1000, 8, 4'd1, 3'd0, 3'd2, 4'b1101, 1'b1);
    // At A press left: wraps to D, then C.
    vecs[14] = v(1, 4'b0010, 2, 4'd0, 3'd3, 3'd0, 4'b0111, 1'b0);
    vecs[15] = v(0, 4'b0010, 1, 4'd0, DB ? 3'd3 : 3'd2, 3'd0, 4'b0111, 1'b0);
    vecs[16] = v(0, 4'b0010, 5, 4'd4, 3'd2, 3'd2, 4'b1101, 1'b1);
    vecs[17] = v(0, 4'b0010, 8, 4'd3, 3'd2, 3'd0, 4'b0111, 1'b1);
    // Up and left together: up wins, held buttons give no further events.
    vecs[18] = v(1, 4'b1010, 10, 4'd5, 3'd0, 3'd2, 4'b1101, 1'b0);
    vecs[19] = v(0, 4'b1010, 10, 4'd0, 3'd0, 3'd1, 4'b1011, 1'b0);
    vecs[20] = v(0, 4'b1010, 20, 4'd5, 3'd0, 3'd2, 4'b1101, 1'b1);
    // Down pulsed for 3 cycles: rejected by debounce, accepted without.
    vecs[21] = v(1, 4'b0100, 3, 4'd0, DB ? 3'd3 : 3'd1, 3'd0, 4'b0111, 1'b0);
    vecs[22] = v(0, 4'b0000, 9, DB ? 4'd1 : 4'd5, DB ? 3'd3 : 3'd1, 3'd3, 4'b1110, 1'b0);
    // Down held: heading lands at edge 3 (or edge 8 with debounce, on the move edge).
    vecs[23] = v(1, 4'b0100, 7, 4'd0, DB ? 3'd3 : 3'd1, 3'd1, 4'b1011, 1'b0);
    vecs[24] = v(0, 4'b0100, 1, 4'd5, 3'd1, 3'd2, 4'b1101, 1'b1);
    vecs[25] = v(0, 4'b0100, 2, 4'd5, 3'd1, 3'd2, 4'b1101, 1'b0);
    // Mid-run reset with left held through it; one event after release.
    vecs[26] = v(0, 4'b0010, 5, 4'd5, DB ? 3'd1 : 3'd2, 3'd3, 4'b1110, 1'b0);
    vecs[27] = v(1, 4'b0010, 0, 4'd0, 3'd3, 3'd0, 4'b0111, 1'b0);
    vecs[28] = v(0, 4'b0010, 10, 4'd4, 3'd2, 3'd2, 4'b1101, 1'b0);
    vecs[29] = v(0, 4'b0000, 6, 4'd3, 3'd2, 3'd0, 4'b0111, 1'b1);

    rst = 1'b0;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      {btn_up, btn_down, btn_left, btn_right} = vecs[i].btn;
      if (vecs[i].do_rst) do_reset();
      exp_q.push_back(vecs[i]);
      repeat (vecs[i].ncyc) @(posedge clk);
      if (vecs[i].ncyc != 0) @(negedge clk);
      e = exp_q.pop_front();
      chk("state",      i, 32'(state),      32'(e.st));
      chk("direction",  i, 32'(direction),  32'(e.dir));
      chk("idx",        i, 32'(idx),        32'(e.ix));
      chk("anodes",     i, 32'(anodes),     32'(e.an));
      chk("move_pulse", i, 32'(move_pulse), 32'(e.pl));
    end

    // move_pulse must be high exactly on edges 8, 16, 24, 32 after release.
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    do_reset();
    pulses = 0;
    for (int n = 1; n <= 32; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (move_pulse) pulses++;
      chk("pulse_cycle", n, 32'(move_pulse), (n % 8 == 0) ? 32'd1 : 32'd0);
    end
    chk("pulse_count", 0, 32'(pulses), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
